// File: rtl/req_gnt_pkg.sv
// rtl/req_gnt_pkg.sv - shared types and helpers for the req/gnt protocol checker
package req_gnt_pkg;

    typedef enum logic [1:0] {
        TIMEOUT  = 2'd0,
        EARLY    = 2'd1,
        SPURIOUS = 2'd2,
        OVERFLOW = 2'd3
    } err_kind_e;

    localparam int N_ERR_KINDS = 4;

    // One extra bit beyond what MAX_LAT+1 needs keeps modular age unambiguous.
    function automatic int calc_ts_w(input int max_lat);
        return $clog2(max_lat + 2) + 1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/req_gnt_chan.sv
// rtl/req_gnt_chan.sv - one channel: timestamp FIFO, timeout/grant/request ordering, error pulses
module req_gnt_chan
    import req_gnt_pkg::*;
#(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int TS_W    = 3,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   gnt,
    input  logic [TS_W-1:0]        now,
    output logic [N_ERR_KINDS-1:0] ev,
    output logic                   pass,
`ifdef REQ_GNT_CHECKER_ASSERT_EN
    output logic                   pass_at_max,
`endif
    output logic [N_ERR_KINDS-1:0] err,
    output logic [CW-1:0]          count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TS_W-1:0] ts_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic [TS_W-1:0] head_age;
    logic [TS_W-1:0] grant_age;
    logic            do_timeout;
    logic [AW-1:0]   rd_ptr1;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   cnt1;
    logic [CW-1:0]   cnt2;
    logic [CW-1:0]   count_next;
    logic            has_head;
    logic            is_early;
    logic            pop_gnt;
    logic            full;
    logic            push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ages are modulo 2^TS_W; the FIFO is in issue order so the head is always oldest.
    always_comb begin
        ev         = '0;
        head_age   = now - ts_mem[rd_ptr];
        do_timeout = (count != '0) && (head_age == TS_W'(MAX_LAT + 1));
        rd_ptr1    = do_timeout ? ptr_inc(rd_ptr) : rd_ptr;
        cnt1       = count - CW'(do_timeout);

        grant_age  = now - ts_mem[rd_ptr1];
        has_head   = (cnt1 != '0);
        pop_gnt    = gnt && has_head;
        is_early   = pop_gnt && (grant_age < TS_W'(MIN_LAT));
        pass       = pop_gnt && !is_early;
        rd_next    = pop_gnt ? ptr_inc(rd_ptr1) : rd_ptr1;
        cnt2       = cnt1 - CW'(pop_gnt);

        full       = (cnt2 == CW'(DEPTH));
        push       = req && !full;
        count_next = cnt2 + CW'(push);

        ev[TIMEOUT]  = do_timeout;
        ev[EARLY]    = is_early;
        ev[SPURIOUS] = gnt && !has_head;
        ev[OVERFLOW] = req && full;
    end

`ifdef REQ_GNT_CHECKER_ASSERT_EN
    assign pass_at_max = pass && (grant_age == TS_W'(MAX_LAT));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= push ? ptr_inc(wr_ptr) : wr_ptr;
            count  <= count_next;
            err    <= ev;
        end
    end

    // When full and popped this cycle, wr_ptr aliases the retired head slot.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ts_mem[wr_ptr] <= now;
        end
    end

endmodule

// File: rtl/req_gnt_checker.sv
// rtl/req_gnt_checker.sv - passive multi-channel req/gnt latency checker with counters
// Optional SVA and covers compiled in with REQ_GNT_CHECKER_ASSERT_EN.
module req_gnt_checker
    import req_gnt_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NCH-1:0]                    req,
    input  logic [NCH-1:0]                    gnt,
    output logic [NCH-1:0]                    err_timeout,
    output logic [NCH-1:0]                    err_early,
    output logic [NCH-1:0]                    err_spurious,
    output logic [NCH-1:0]                    err_overflow,
    output logic [NCH-1:0]                    err_sticky,
    output logic [NCH*$clog2(DEPTH+1)-1:0]    pending,
    output logic [CNT_W-1:0]                  pass_cnt,
    output logic [CNT_W-1:0]                  viol_cnt
);

    localparam int          PW      = $clog2(DEPTH + 1);
    localparam int          TS_W    = calc_ts_w(MAX_LAT);
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic [TS_W-1:0]        now;
    logic [N_ERR_KINDS-1:0] ch_ev  [NCH];
    logic [N_ERR_KINDS-1:0] ch_err [NCH];
    logic [NCH-1:0]         ch_pass;
    logic [NCH-1:0]         any_ev;
    logic [31:0]            pass_add;
    logic [31:0]            viol_add;
`ifdef REQ_GNT_CHECKER_ASSERT_EN
    logic [NCH-1:0]         ch_pass_max;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        req_gnt_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT),
            .DEPTH   (DEPTH),
            .TS_W    (TS_W),
            .CW      (PW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .req         (req[g]),
            .gnt         (gnt[g]),
            .now         (now),
            .ev          (ch_ev[g]),
            .pass        (ch_pass[g]),
`ifdef REQ_GNT_CHECKER_ASSERT_EN
            .pass_at_max (ch_pass_max[g]),
`endif
            .err         (ch_err[g]),
            .count       (pending[g*PW +: PW])
        );

        assign err_timeout[g]  = ch_err[g][TIMEOUT];
        assign err_early[g]    = ch_err[g][EARLY];
        assign err_spurious[g] = ch_err[g][SPURIOUS];
        assign err_overflow[g] = ch_err[g][OVERFLOW];
        assign any_ev[g]       = |ch_ev[g];
    end

    always_comb begin
        pass_add = '0;
        viol_add = '0;
        for (int i = 0; i < NCH; i++) begin
            pass_add = pass_add + 32'(ch_pass[i]);
            viol_add = viol_add + 32'($countones(ch_ev[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            now        <= '0;
            err_sticky <= '0;
            pass_cnt   <= '0;
            viol_cnt   <= '0;
        end else begin
            now        <= now + 1'b1;
            err_sticky <= err_sticky | any_ev;
            pass_cnt   <= CNT_W'(sat_add(32'(pass_cnt), pass_add, CNT_MAX));
            viol_cnt   <= CNT_W'(sat_add(32'(viol_cnt), viol_add, CNT_MAX));
        end
    end

`ifdef REQ_GNT_CHECKER_ASSERT_EN
    for (genvar g = 0; g < NCH; g++) begin : g_sva
        a_timeout : assert property (@(posedge clk) disable iff (rst) !err_timeout[g])
            else $error("req_gnt_checker: timeout ch %0d now %0d", g, now);
        a_early : assert property (@(posedge clk) disable iff (rst) !err_early[g])
            else $error("req_gnt_checker: early grant ch %0d now %0d", g, now);
        a_spurious : assert property (@(posedge clk) disable iff (rst) !err_spurious[g])
            else $error("req_gnt_checker: spurious grant ch %0d now %0d", g, now);
        a_overflow : assert property (@(posedge clk) disable iff (rst) !err_overflow[g])
            else $error("req_gnt_checker: queue overflow ch %0d now %0d", g, now);
        c_max_lat : cover property (@(posedge clk) disable iff (rst) ch_pass_max[g]);
    end
`endif

endmodule
